// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, timing defaults and command codes for the LCD nibble writer
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HI_SETUP,
    ST_HI_PULSE,
    ST_HI_HOLD,
    ST_GAP,
    ST_LO_SETUP,
    ST_LO_PULSE,
    ST_LO_HOLD,
    ST_WAIT
  } lcd_state_e;

  // Default timings in 50 MHz clock cycles
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_PULSE_CYCLES = 12;
  localparam int DEF_HOLD_CYCLES  = 1;
  localparam int DEF_GAP_CYCLES   = 50;
  localparam int DEF_WAIT_CYCLES  = 2000;
  localparam int DEF_CLEAR_CYCLES = 82000;
  localparam int DEF_CNT_W        = 20;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear and return-home (bit 0 is don't-care for home) need the long execution wait
  function automatic logic is_long_cmd(input logic [7:0] cmd);
    return (cmd == CMD_CLEAR) || (cmd == CMD_HOME) || (cmd == (CMD_HOME | 8'h01));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - loadable down-counter with zero flag for state timing
module lcd_delay_counter #(
  parameter int CNT_W = 20
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - byte-to-nibble timing engine driving 4-bit character LCD pins
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  input  logic       iNibbleOnly,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl
);

  // Counter loads are N-1 so that each timed state lasts exactly N cycles
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_CYCLES - 1);

  lcd_state_e       state, state_n;
  logic [7:0]       byte_q, byte_n;
  logic             rs_q, rs_n;
  logic             nib_q, nib_n;
  logic             accept;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             long_wait;
  logic             e_n;
  logic             rs_out_n;
  logic [3:0]       data_n;
  logic             ready_n;
  logic             done_n;

  assign accept = iWrite && oReady;

  lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  // State, latched write and all pin outputs are registered together
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state               <= ST_IDLE;
      byte_q              <= '0;
      rs_q                <= 1'b0;
      nib_q               <= 1'b0;
      oReady              <= 1'b1;
      oDone               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= '0;
    end else begin
      state               <= state_n;
      byte_q              <= byte_n;
      rs_q                <= rs_n;
      nib_q               <= nib_n;
      oReady              <= ready_n;
      oDone               <= done_n;
      oLCD_Enabled        <= e_n;
      oLCD_RegisterSelect <= rs_out_n;
      oLCD_Data           <= data_n;
    end
  end

  // Next state, latch capture, counter load and next pin values derived from the next state
  always_comb begin
    state_n   = state;
    byte_n    = byte_q;
    rs_n      = rs_q;
    nib_n     = nib_q;
    cnt_value = '0;
    e_n       = 1'b0;
    data_n    = '0;
    rs_out_n  = 1'b0;
    done_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          byte_n  = iData;
          rs_n    = iRegisterSelect;
          nib_n   = iNibbleOnly;
          state_n = iNibbleOnly ? ST_LO_SETUP : ST_HI_SETUP;
        end
      end
      ST_HI_SETUP: if (cnt_zero) state_n = ST_HI_PULSE;
      ST_HI_PULSE: if (cnt_zero) state_n = ST_HI_HOLD;
      ST_HI_HOLD:  if (cnt_zero) state_n = ST_GAP;
      ST_GAP:      if (cnt_zero) state_n = ST_LO_SETUP;
      ST_LO_SETUP: if (cnt_zero) state_n = ST_LO_PULSE;
      ST_LO_PULSE: if (cnt_zero) state_n = ST_LO_HOLD;
      ST_LO_HOLD:  if (cnt_zero) state_n = ST_WAIT;
      ST_WAIT: begin
        if (cnt_zero) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    long_wait = !rs_n && !nib_n && is_long_cmd(byte_n);
    cnt_load  = (state_n != state);

    case (state_n)
      ST_HI_SETUP, ST_LO_SETUP: cnt_value = LD_SETUP;
      ST_HI_PULSE, ST_LO_PULSE: cnt_value = LD_PULSE;
      ST_HI_HOLD, ST_LO_HOLD:   cnt_value = LD_HOLD;
      ST_GAP:                   cnt_value = LD_GAP;
      ST_WAIT:                  cnt_value = long_wait ? LD_CLEAR : LD_WAIT;
      default:                  cnt_value = '0;
    endcase

    case (state_n)
      ST_HI_SETUP, ST_HI_HOLD:  data_n = byte_n[7:4];
      ST_HI_PULSE: begin
        data_n = byte_n[7:4];
        e_n    = 1'b1;
      end
      ST_LO_SETUP, ST_LO_HOLD:  data_n = byte_n[3:0];
      ST_LO_PULSE: begin
        data_n = byte_n[3:0];
        e_n    = 1'b1;
      end
      default:                  data_n = '0;
    endcase

    rs_out_n = (state_n != ST_IDLE) ? rs_n : 1'b0;
    ready_n  = (state_n == ST_IDLE);
  end

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule
